dds_multichannel: RTL and testbench
===================================

// Module: dds_multichannel
// PURPOSE
//   Parametrised successor to the single-channel DDS. N_CH independent sine channels
//   share one writable waveform LUT, and each channel has its own tuning word and phase offset.
//   LUT reads are time-multiplexed round-robin: one channel per clock, one frame = N_CH clocks.
//   It sits between the host/config loader (LUT + register writes) and the DAC output stage.
// PARAMETERS
//   DATA_LEN     8   LUT word / output sample width (bits)
//   ROWS_BASE_2  9   LUT address width; LUT depth = 2**ROWS_BASE_2
//   ACC_W        24  phase accumulator width, ACC_W >= ROWS_BASE_2
//   N_CH         2   channel count, 1..16
//   CH_W         4   channel-select width, 2**CH_W >= N_CH
// PORTS
//   src_clk      in   1                 single clock, rising edge
//   rst_n        in   1                 asynchronous reset, active-low
//   we           in   1                 LUT write enable
//   addr_wr      in   ROWS_BASE_2       LUT write address
//   data_wr      in   DATA_LEN          LUT write data
//   ch_sel       in   CH_W              target channel for set_phase / set_ftw
//   set_phase    in   1                 load phase offset of ch_sel from phase
//   phase        in   ROWS_BASE_2       phase offset in LUT-address units
//   set_ftw      in   1                 load tuning word of ch_sel from ftw
//   ftw          in   ACC_W             frequency tuning word
//   enable       in   1                 accumulators advance only while 1
//   sinwave      out  N_CH*DATA_LEN     channel c on bits [c*DATA_LEN +: DATA_LEN]
//   sample_valid out  1                 1-cycle pulse when a full frame has been output
// BEHAVIOUR
//   Reset (rst_n=0, async): all acc, ftw_r and off_r = 0; slot = 0; pipeline regs = 0;
//     sinwave = 0; sample_valid = 0. LUT contents are NOT reset.
//   LUT: sync write when we=1. Sync read, 1 cycle. A write has priority over a read.
//   Slot counter: counts 0..N_CH-1 and wraps to 0. It advances every cycle while we=0.
//   While we=1 the whole read pipeline stalls: slot, acc and pipeline regs hold, and
//     sinwave holds its last value.
//   Read address for slot s: rd_addr = acc[s][ACC_W-1 -: ROWS_BASE_2] + off_r[s],
//     computed modulo 2**ROWS_BASE_2 (wrap, no saturation).
//   Pipeline for slot s:
//     cycle t:     rd_addr presented to the LUT.
//     cycle t+1:   LUT data registered.
//     end of t+1:  data written to sinwave slice s.
//   Total latency: 2 cycles, addr -> sinwave.
//   Accumulator update: on the edge that ends slot N_CH-1, and only if enable=1,
//     every acc[c] <= acc[c] + ftw_r[c], modulo 2**ACC_W. All channels update in the same edge.
//   sample_valid: pulses for 1 cycle in the cycle in which slice N_CH-1 has just been updated.
//   Config writes:
//     set_phase -> off_r[ch_sel] <= phase.
//     set_ftw   -> ftw_r[ch_sel] <= ftw.
//     Both may be asserted in the same cycle; each takes effect on the following cycle's
//       address or accumulator computation.
//     An accumulator update in the same edge uses the old ftw_r.
//     ch_sel >= N_CH: the write is ignored and no register changes.
//     Config writes are accepted while we=1.
//   enable=0: acc values freeze, but slots keep cycling, so offset changes still show
//     at the output.
//   Reset mid-frame: everything returns immediately to the reset state.
//     The first sample_valid after rst_n rises comes N_CH+1 cycles later (with we=0).
// TESTING
//   1 Reset: rst_n=0 with we=0 -> sinwave=0, sample_valid=0; release -> first
//     sample_valid after N_CH+1=3 cycles.
//   2 Ramp load: write LUT[a]=a[7:0] for a=0..511.
//     ftw=0x008000 on ch0 and ch1, enable=1 -> both channels step by +1 per frame
//       (sequence 0,1,2,...).
//     After 255 the output wraps to 0; at address 511 the read wraps to address 0.
//   3 Phase offset: with scenario 2 running, set_phase=1, ch_sel=1, phase=90 for one cycle
//     -> from the next frame, ch1 = (ch0+90) mod 256; ch0 is unaffected.
//   4 Stall: assert we for 10 cycles mid-run -> sinwave, acc and slot all hold, and no
//     sample_valid occurs.
//     Deassert we -> the sequence resumes with no skipped value.
//   5 Invalid channel: set_ftw with ch_sel=5 and ftw=0xFFFFFF -> no channel changes frequency.
//   6 Freeze and wrap:
//     enable=0 -> outputs stay constant, while sample_valid keeps pulsing every 2 cycles.
//     ftw=0x800000 -> the address alternates between 0 and 256 each frame
//       (accumulator wrap check).

Source files
------------

// File: rtl/dds_multichannel.sv
// Multichannel DDS: N_CH sine channels share one writable waveform LUT.
// Channels are served round-robin, one LUT read per clock. Each channel owns a
// phase accumulator, a tuning word and a phase offset. A LUT write stalls the
// whole read pipeline for that cycle.
module dds_multichannel #(
  parameter int unsigned DATA_LEN    = 8,
  parameter int unsigned ROWS_BASE_2 = 9,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CH_W        = 4
) (
  input  logic                     src_clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ROWS_BASE_2-1:0]   addr_wr,
  input  logic [DATA_LEN-1:0]      data_wr,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic                     set_phase,
  input  logic [ROWS_BASE_2-1:0]   phase,
  input  logic                     set_ftw,
  input  logic [ACC_W-1:0]         ftw,
  input  logic                     enable,
  output logic [N_CH*DATA_LEN-1:0] sinwave,
  output logic                     sample_valid
);

  localparam int unsigned Depth = 2 ** ROWS_BASE_2;
  localparam logic [CH_W-1:0] LastSlot = CH_W'(N_CH - 1);

  logic [DATA_LEN-1:0]      lut_mem [Depth];

  logic [ACC_W-1:0]         acc_q   [N_CH];
  logic [ACC_W-1:0]         ftw_q   [N_CH];
  logic [ROWS_BASE_2-1:0]   off_q   [N_CH];

  logic [CH_W-1:0]          slot_q, slot_d;
  logic                     frame_end;
  logic [ACC_W-1:0]         acc_sel;
  logic [ROWS_BASE_2-1:0]   off_sel;
  logic [ROWS_BASE_2-1:0]   rd_addr;

  // Read pipeline: LUT data plus the slot it belongs to.
  logic [DATA_LEN-1:0]      rd_data_q;
  logic [CH_W-1:0]          rd_slot_q;
  logic                     rd_vld_q;

  logic [N_CH*DATA_LEN-1:0] sin_q;
  logic                     sv_q;

  assign frame_end = (slot_q == LastSlot);
  assign slot_d    = frame_end ? '0 : slot_q + 1'b1;

  // Select accumulator and offset of the slot being served this cycle.
  always_comb begin
    acc_sel = '0;
    off_sel = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (slot_q == CH_W'(c)) begin
        acc_sel = acc_q[c];
        off_sel = off_q[c];
      end
    end
  end

  // Phase-to-address: top accumulator bits plus offset, wrapping modulo LUT depth.
  assign rd_addr = acc_sel[ACC_W-1 -: ROWS_BASE_2] + off_sel;

  // LUT write port; contents intentionally survive reset.
  always_ff @(posedge src_clk) begin
    if (we) begin
      lut_mem[addr_wr] <= data_wr;
    end
  end

  // Slot counter and read pipeline; everything holds while a LUT write is in progress.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      rd_data_q <= '0;
      rd_slot_q <= '0;
      rd_vld_q  <= 1'b0;
      sin_q     <= '0;
      sv_q      <= 1'b0;
    end else if (!we) begin
      slot_q    <= slot_d;
      rd_data_q <= lut_mem[rd_addr];
      rd_slot_q <= slot_q;
      rd_vld_q  <= 1'b1;
      sv_q      <= rd_vld_q && (rd_slot_q == LastSlot);
      if (rd_vld_q) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          if (rd_slot_q == CH_W'(c)) begin
            sin_q[c*DATA_LEN +: DATA_LEN] <= rd_data_q;
          end
        end
      end
    end else begin
      sv_q <= 1'b0;
    end
  end

  // Accumulators advance once per frame; config writes to out-of-range channels match nothing.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc_q[c] <= '0;
        ftw_q[c] <= '0;
        off_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (!we && frame_end && enable) begin
          acc_q[c] <= acc_q[c] + ftw_q[c];
        end
        if (set_phase && (ch_sel == CH_W'(c))) begin
          off_q[c] <= phase;
        end
        if (set_ftw && (ch_sel == CH_W'(c))) begin
          ftw_q[c] <= ftw;
        end
      end
    end
  end

  assign sinwave      = sin_q;
  assign sample_valid = sv_q;

endmodule

// File: tb/tb_dds_multichannel.sv
// Self-checking bench for dds_multichannel: behavioural model plus literal checks.
module tb_dds_multichannel;

  localparam int DL   = 8;
  localparam int RB   = 9;
  localparam int AW   = 24;
  localparam int NC   = 2;
  localparam int CW   = 4;
  localparam int LUTN = 2 ** RB;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            we;
  logic [RB-1:0]   addr_wr;
  logic [DL-1:0]   data_wr;
  logic [CW-1:0]   ch_sel;
  logic            set_phase;
  logic [RB-1:0]   phase;
  logic            set_ftw;
  logic [AW-1:0]   ftw;
  logic            enable;
  logic [NC*DL-1:0] sinwave;
  logic            sample_valid;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  dds_multichannel #(
    .DATA_LEN(DL), .ROWS_BASE_2(RB), .ACC_W(AW), .N_CH(NC), .CH_W(CW)
  ) dut (
    .src_clk(clk), .rst_n(rst_n), .we(we), .addr_wr(addr_wr), .data_wr(data_wr),
    .ch_sel(ch_sel), .set_phase(set_phase), .phase(phase), .set_ftw(set_ftw), .ftw(ftw),
    .enable(enable), .sinwave(sinwave), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int          ch;
    logic [DL-1:0] val;
  } rd_t;

  logic [DL-1:0]    m_lut [LUTN];
  logic [AW-1:0]    m_acc [NC];
  logic [AW-1:0]    m_ftw [NC];
  logic [RB-1:0]    m_off [NC];
  int               m_slot;
  rd_t              m_pipe [$];
  logic [NC*DL-1:0] m_sin;
  logic             m_sv;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_acc[c] = '0;
      m_ftw[c] = '0;
      m_off[c] = '0;
    end
    m_slot = 0;
    m_pipe.delete();
    m_sin = '0;
    m_sv = 1'b0;
  endfunction

  // One clock edge of the spec: a sample read for a slot lands on the output one
  // non-stalled edge later; accumulators step after the last slot of a frame.
  function automatic void model_edge();
    rd_t r;
    if (we) m_lut[addr_wr] = data_wr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_sv = 1'b0;
    if (!we) begin
      if (m_pipe.size() > 0) begin
        r = m_pipe.pop_front();
        m_sin[r.ch*DL +: DL] = r.val;
        m_sv = (r.ch == NC - 1);
      end
      r.ch  = m_slot;
      r.val = m_lut[RB'((m_acc[m_slot] >> (AW - RB)) + m_off[m_slot])];
      m_pipe.push_back(r);
      if (m_slot == NC - 1 && enable) begin
        for (int c = 0; c < NC; c++) m_acc[c] = m_acc[c] + m_ftw[c];
      end
      m_slot = (m_slot + 1) % NC;
    end
    if (int'(ch_sel) < NC) begin
      if (set_phase) m_off[ch_sel] = phase;
      if (set_ftw)   m_ftw[ch_sel] = ftw;
    end
  endfunction

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sinwave", 64'(sinwave), 64'(m_sin));
      check("sample_valid", 64'(sample_valid), 64'(m_sv));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    set_phase = 1'b0;
    set_ftw   = 1'b0;
    we        = 1'b0;
  endtask

  task automatic wait_sv(output logic [DL-1:0] c0, output logic [DL-1:0] c1);
    int n = 0;
    do begin
      step();
      n++;
    end while (!sample_valid && n < 8);
    if (!sample_valid) check("sv_timeout", 64'(n), 64'(0));
    c0 = sinwave[DL-1:0];
    c1 = sinwave[2*DL-1:DL];
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DL-1:0] c0, c1, p0, p1;
    logic [NC*DL-1:0] snap;
    int n, svs;

    rst_n = 1'b1; we = 0; addr_wr = 0; data_wr = 0; ch_sel = 0;
    set_phase = 0; phase = 0; set_ftw = 0; ftw = 0; enable = 0;
    model_reset();
    #2 rst_n = 1'b0;
    chk_en = 1'b1;

    // 1/2: load ramp LUT while held in reset
    for (int a = 0; a < LUTN; a++) begin
      we = 1'b1; addr_wr = RB'(a); data_wr = DL'(a);
      step();
    end
    we = 1'b0;
    step();
    check("rst_sinwave", 64'(sinwave), 64'(0));
    check("rst_sample_valid", 64'(sample_valid), 64'(0));

    // Release and measure latency to first sample_valid while configuring
    rst_n = 1'b1;
    n = 0;
    do begin
      clear_pulses();
      if (n == 0) begin set_ftw = 1; ch_sel = 0; ftw = 24'h008000; end
      if (n == 1) begin set_ftw = 1; ch_sel = 1; ftw = 24'h008000; end
      step();
      n++;
    end while (!sample_valid && n < 10);
    clear_pulses();
    check("first_sv_latency", 64'(n), 64'(NC + 1));

    // Ramp: both channels count up by one per frame, wrapping through 255 and addr 511
    enable = 1'b1;
    wait_sv(c0, c1);
    wait_sv(p0, p1);
    for (int k = 0; k < 520; k++) begin
      wait_sv(c0, c1);
      check("ramp_step", 64'(c0), 64'(DL'(p0 + 1)));
      if (k % 64 == 0) check("ramp_ch_equal", 64'(c1), 64'(c0));
      p0 = c0;
    end

    // 3: phase offset on ch1
    set_phase = 1; ch_sel = 1; phase = 9'd90;
    step();
    clear_pulses();
    wait_sv(c0, c1);
    for (int k = 0; k < 4; k++) begin
      wait_sv(c0, c1);
      check("phase_offset", 64'(c1), 64'(DL'(c0 + 8'd90)));
    end
    p0 = c0;

    // 4: stall for 10 cycles, rewriting the ramp so LUT content is unchanged
    snap = sinwave;
    for (int k = 0; k < 10; k++) begin
      we = 1'b1; addr_wr = RB'($urandom_range(LUTN - 1)); data_wr = DL'(addr_wr);
      step();
      check("stall_no_sv", 64'(sample_valid), 64'(0));
      check("stall_hold", 64'(sinwave), 64'(snap));
    end
    clear_pulses();
    wait_sv(c0, c1);
    check("stall_resume", 64'(c0), 64'(DL'(p0 + 1)));
    p0 = c0;

    // 5: invalid channel write must not change any frequency
    set_ftw = 1; ch_sel = 4'd5; ftw = 24'hFFFFFF;
    step();
    clear_pulses();
    for (int k = 0; k < 3; k++) begin
      wait_sv(c0, c1);
      check("invalid_ch_step", 64'(c0), 64'(DL'(p0 + 1)));
      p0 = c0;
    end

    // 6: reset mid-frame, freeze, then half-scale tuning word
    rst_n = 1'b0;
    step();
    check("midreset_sinwave", 64'(sinwave), 64'(0));
    rst_n = 1'b1;
    enable = 1'b0;
    we = 1'b1; addr_wr = 9'd256; data_wr = 8'hAA;
    step();
    clear_pulses();
    set_ftw = 1; ch_sel = 0; ftw = 24'h800000;
    step();
    clear_pulses();
    repeat (4) step();
    snap = sinwave;
    check("freeze_ch0_zero", 64'(sinwave[DL-1:0]), 64'(0));
    svs = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (sample_valid) svs++;
      check("freeze_hold", 64'(sinwave), 64'(snap));
    end
    check("freeze_sv_count", 64'(svs), 64'(5));
    enable = 1'b1;
    wait_sv(c0, c1);
    wait_sv(p0, p1);
    for (int k = 0; k < 6; k++) begin
      wait_sv(c0, c1);
      check("acc_wrap_alt", 64'(c0), 64'(p0 ^ 8'hAA));
      p0 = c0;
    end

    // Randomized config, LUT writes and enable toggling against the model
    for (int k = 0; k < 400; k++) begin
      set_phase = ($urandom_range(3) == 0);
      set_ftw   = ($urandom_range(5) == 0);
      ch_sel    = CW'($urandom_range(3));
      phase     = RB'($urandom);
      ftw       = AW'($urandom);
      enable    = ($urandom_range(7) != 0);
      we        = ($urandom_range(9) == 0);
      addr_wr   = RB'($urandom);
      data_wr   = DL'($urandom);
      step();
    end
    clear_pulses();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
